// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with a memory-ready handshake, a watchdog trap and illegal-opcode reporting.
// Optional feature macro: MULTICYCLE_CTRL_JUMP_EN (makes opcode 000010 'j' legal).
module multicycle_ctrl #(
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [5:0]          instr_op_i,
   input  logic                mem_ready_i,
   output logic                pc_write_o,
   output logic                ir_write_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic                reg_write_o,
   output logic                reg_dst_o,
   output logic                alu_src_o,
   output logic                mem_to_reg_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output logic                branch_o,
   output logic                branch_ne_o,
   output logic                jump_o,
   output logic                instr_done_o,
   output logic                illegal_o,
   output logic                err_o,
   output logic [2:0]          state_o
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_ERR = 3'd7
   } state_t;

   typedef struct packed {
      logic [2:0] alu;
      logic       src;
      logic       dst;
      logic       is_lw;
      logic       is_sw;
      logic       is_br;
      logic       is_bne;
      logic       is_j;
   } dec_t;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic [2:0] alu_op;
      logic       branch;
      logic       branch_ne;
      logic       instr_done;
      logic       illegal;
      logic       err;
   } ctrl_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Last tolerated wait cycle: a miss here makes MEM_TIMEOUT consecutive misses.
   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   function automatic logic legal_op(input logic [5:0] op);
      case (op)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
         OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: legal_op = 1'b1;
`ifdef MULTICYCLE_CTRL_JUMP_EN
         OP_J:                              legal_op = 1'b1;
`endif
         default:                           legal_op = 1'b0;
      endcase
   endfunction

   function automatic dec_t decode(input logic [5:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_R:     begin d.alu = 3'b010; d.dst = 1'b1; end
         OP_LW:    begin d.alu = 3'b000; d.src = 1'b1; d.is_lw = 1'b1; end
         OP_SW:    begin d.alu = 3'b000; d.src = 1'b1; d.is_sw = 1'b1; end
         OP_BEQ:   begin d.alu = 3'b001; d.is_br = 1'b1; end
         OP_BNE:   begin d.alu = 3'b101; d.is_br = 1'b1; d.is_bne = 1'b1; end
         OP_ADDI:  begin d.alu = 3'b000; d.src = 1'b1; end
         OP_SLTIU: begin d.alu = 3'b010; d.src = 1'b1; end
         OP_LUI:   begin d.alu = 3'b110; d.src = 1'b1; end
         OP_ORI:   begin d.alu = 3'b100; d.src = 1'b1; end
`ifdef MULTICYCLE_CTRL_JUMP_EN
         OP_J:     d.is_j = 1'b1;
`endif
         default:  d = '0;
      endcase
      return d;
   endfunction

   state_t     state_q, state_d;
   logic [5:0] op_q;
   logic [7:0] cnt_q;
   dec_t       dq;
   ctrl_t      c;
   logic       id_legal;
   logic       wait_miss;

   assign dq        = decode(op_q);
   assign id_legal  = legal_op(instr_op_i);
   assign wait_miss = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IF;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                   op_q <= '0;
      else if (state_q == S_ID)    op_q <= instr_op_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                   cnt_q <= '0;
      else if (state_d != state_q) cnt_q <= '0;
      else if (wait_miss)          cnt_q <= cnt_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF: begin
            if (mem_ready_i)            state_d = S_ID;
            else if (cnt_q == TO_LAST)  state_d = S_ERR;
         end
         S_ID:  state_d = id_legal ? S_EX : S_IF;
         S_EX: begin
            if (dq.is_br || dq.is_j)      state_d = S_IF;
            else if (dq.is_lw || dq.is_sw) state_d = S_MEM;
            else                           state_d = S_WB;
         end
         S_MEM: begin
            if (mem_ready_i)            state_d = dq.is_lw ? S_WB : S_IF;
            else if (cnt_q == TO_LAST)  state_d = S_ERR;
         end
         S_WB:  state_d = S_IF;
         S_ERR: state_d = S_ERR;
         default: state_d = S_IF;
      endcase
   end

   // Moore decode; only the IF fetch strobes look at mem_ready_i.
   always_comb begin
      c = '0;
      case (state_q)
         S_IF: begin
            c.mem_read = 1'b1;
            c.pc_write = mem_ready_i;
            c.ir_write = mem_ready_i;
         end
         S_ID: begin
            c.illegal    = !id_legal;
            c.instr_done = !id_legal;
         end
         S_EX: begin
            c.alu_op     = dq.alu;
            c.alu_src    = dq.src;
            c.reg_dst    = dq.dst;
            c.branch     = dq.is_br;
            c.branch_ne  = dq.is_bne;
            c.pc_write   = dq.is_j;
            c.instr_done = dq.is_br | dq.is_j;
         end
         S_MEM: begin
            c.alu_op     = dq.alu;
            c.alu_src    = dq.src;
            c.reg_dst    = dq.dst;
            c.mem_read   = dq.is_lw;
            c.mem_write  = dq.is_sw;
            c.instr_done = dq.is_sw;
         end
         S_WB: begin
            c.alu_op     = dq.alu;
            c.alu_src    = dq.src;
            c.reg_dst    = dq.dst;
            c.reg_write  = 1'b1;
            c.mem_to_reg = dq.is_lw;
            c.instr_done = 1'b1;
         end
         S_ERR: c.err = 1'b1;
         default: c = '0;
      endcase
   end

   assign pc_write_o   = c.pc_write   & ~rst_i;
   assign ir_write_o   = c.ir_write   & ~rst_i;
   assign mem_read_o   = c.mem_read   & ~rst_i;
   assign mem_write_o  = c.mem_write  & ~rst_i;
   assign reg_write_o  = c.reg_write  & ~rst_i;
   assign reg_dst_o    = c.reg_dst    & ~rst_i;
   assign alu_src_o    = c.alu_src    & ~rst_i;
   assign mem_to_reg_o = c.mem_to_reg & ~rst_i;
   assign alu_op_o     = rst_i ? '0 : ALU_OP_W'(c.alu_op);
   assign branch_o     = c.branch     & ~rst_i;
   assign branch_ne_o  = c.branch_ne  & ~rst_i;
   assign instr_done_o = c.instr_done & ~rst_i;
   assign illegal_o    = c.illegal    & ~rst_i;
   assign err_o        = c.err        & ~rst_i;
   assign state_o      = rst_i ? 3'd0 : state_q;

`ifdef MULTICYCLE_CTRL_JUMP_EN
   assign jump_o = ~rst_i & (state_q == S_EX) & dq.is_j;
`else
   assign jump_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random traffic against a flow-list model.
module tb_multicycle_ctrl;

   localparam int T = 15;
   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                          BNE = 6'b000101, ADDI = 6'b001000, SLTIU = 6'b001011, LUI = 6'b001111,
                          ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;

   logic clk = 1'b0, rst = 1'b1, rdy = 1'b0;
   logic [5:0] op = '0;
   logic pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src, mem_to_reg;
   logic [2:0] alu_op, state;
   logic branch, branch_ne, jump, done, illegal, err;
   logic [16:0] dvec;

   multicycle_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(T)) dut (
      .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(rdy),
      .pc_write_o(pc_write), .ir_write_o(ir_write), .mem_read_o(mem_read),
      .mem_write_o(mem_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
      .alu_src_o(alu_src), .mem_to_reg_o(mem_to_reg), .alu_op_o(alu_op),
      .branch_o(branch), .branch_ne_o(branch_ne), .jump_o(jump),
      .instr_done_o(done), .illegal_o(illegal), .err_o(err), .state_o(state)
   );

   always #5 clk = ~clk;

   assign dvec = {pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src,
                  mem_to_reg, alu_op, branch, branch_ne, jump, done, illegal, err};

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
   endtask

   // Model: an instruction is the fetch pair IF,ID followed by its list of post-decode states.
   int m_st = 0, m_idx = 0, m_wait = 0;
   logic [5:0] m_op = '0;

   function automatic logic m_legal(input logic [5:0] o);
`ifdef MULTICYCLE_CTRL_JUMP_EN
      if (o == J) return 1'b1;
`endif
      return o inside {R, LW, SW, BEQ, BNE, ADDI, SLTIU, LUI, ORI};
   endfunction

   function automatic int flow_at(input logic [5:0] o, input int i);
      int f[3];
      case (o)
         LW:         f = '{2, 3, 4};
         SW:         f = '{2, 3, -1};
         BEQ, BNE, J: f = '{2, -1, -1};
         default:    f = '{2, 4, -1};
      endcase
      return (i < 3) ? f[i] : -1;
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] o);
      case (o)
         R, SLTIU: return 3'b010;
         BEQ:      return 3'b001;
         BNE:      return 3'b101;
         LUI:      return 3'b110;
         ORI:      return 3'b100;
         default:  return 3'b000;
      endcase
   endfunction

   function automatic logic [16:0] model_out();
      logic pcw, irw, mr, mw, rw, dst, src, m2r, br, bne, jmp, dn, ill, er;
      logic [2:0] alu;
      {pcw, irw, mr, mw, rw, dst, src, m2r, br, bne, jmp, dn, ill, er} = '0;
      alu = '0;
      if (!rst) begin
         case (m_st)
            0: begin mr = 1'b1; pcw = rdy; irw = rdy; end
            1: if (!m_legal(op)) begin ill = 1'b1; dn = 1'b1; end
            2, 3, 4: begin
               alu = alu_of(m_op);
               src = m_op inside {LW, SW, ADDI, SLTIU, LUI, ORI};
               dst = (m_op == R);
               dn  = (flow_at(m_op, m_idx + 1) < 0);
               if (m_st == 2) begin
                  br = (m_op == BEQ) || (m_op == BNE);
                  bne = (m_op == BNE);
                  jmp = (m_op == J);
                  pcw = jmp;
               end
               if (m_st == 3) begin mr = (m_op == LW); mw = (m_op == SW); end
               if (m_st == 4) begin rw = 1'b1; m2r = (m_op == LW); end
            end
            7: er = 1'b1;
            default: ;
         endcase
      end
      return {pcw, irw, mr, mw, rw, dst, src, m2r, alu, br, bne, jmp, dn, ill, er};
   endfunction

   task automatic model_step();
      if (rst) begin
         m_st = 0; m_wait = 0;
      end else begin
         case (m_st)
            0: if (rdy) begin m_st = 1; m_wait = 0; end
               else begin m_wait++; if (m_wait == T) begin m_st = 7; m_wait = 0; end end
            1: if (m_legal(op)) begin m_op = op; m_idx = 0; m_st = flow_at(op, 0); end
               else m_st = 0;
            2, 3, 4: begin
               if (m_st == 3 && !rdy) begin
                  m_wait++;
                  if (m_wait == T) begin m_st = 7; m_wait = 0; end
               end else begin
                  m_wait = 0;
                  if (flow_at(m_op, m_idx + 1) < 0) m_st = 0;
                  else begin m_idx++; m_st = flow_at(m_op, m_idx); end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input logic r, input logic [5:0] o, input logic y);
      @(negedge clk);
      rst = r; op = o; rdy = y;
      #1;
      chk("state", {29'd0, state}, rst ? 32'd0 : 32'(m_st));
      chk("ctrl", {15'd0, dvec}, {15'd0, model_out()});
      @(posedge clk);
      model_step();
   endtask

   task automatic run(input logic r, input logic [5:0] o, input logic y, input int n);
      for (int i = 0; i < n; i++) cyc(r, o, y);
   endtask

   logic [5:0] pool[12] = '{R, LW, SW, BEQ, BNE, ADDI, SLTIU, LUI, ORI, J, BAD, 6'b110001};

   initial begin
      int stall;
      run(1, R, 0, 3);                        // reset
      run(0, LW, 1, 5);                       // lw zero-wait: 0,1,2,3,4
      run(0, BEQ, 1, 3);
      run(0, BNE, 1, 3);
      run(0, R, 0, 14);                       // 14 misses: no trap
      run(0, R, 1, 4);
      run(0, R, 0, 15);                       // 15 misses: trap
      #1;
      chk("trap_state", {29'd0, state}, 32'd7);
      chk("trap_err", {31'd0, err}, 32'd1);
      run(0, R, 1, 3);                        // ERR holds despite ready
      run(1, R, 1, 2);
      cyc(0, R, 1);
      cyc(0, BAD, 1);                         // illegal in ID
      cyc(0, R, 1);
      cyc(0, J, 1);
      run(0, J, 1, 2);
      run(0, SW, 1, 3);                       // sw stalled in MEM then reset
      run(0, SW, 0, 4);
      run(1, SW, 0, 2);
      run(0, LW, 1, 3);                       // lw stalled in MEM until trap
      run(0, LW, 0, 15);
      run(0, LW, 1, 2);
      run(1, R, 0, 2);
      stall = 0;
      for (int i = 0; i < 3000; i++) begin
         logic r, y;
         if (stall == 0 && $urandom_range(0, 99) == 0) stall = $urandom_range(10, 18);
         r = ($urandom_range(0, 79) == 0);
         y = (stall == 0) && ($urandom_range(0, 3) != 0);
         if (stall > 0) stall--;
         cyc(r, pool[$urandom_range(0, 11)], y);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle MIPS main control unit. It sequences each instruction through the fetch, decode, execute, memory and writeback states, and it drives the same control signals the single-cycle decoder produces, but one state at a time. It sits between the instruction register opcode field and the shared-memory/ALU datapath of the multi-cycle CPU. It adds three things the single-cycle decoder lacks: a memory ready handshake, a watchdog timeout with an error trap, and illegal-opcode reporting.

## Interface
- `ALU_OP_W`, default 3: width of `alu_op_o`. Must be ≥3; the 3-bit codes are zero-extended.
- `MEM_TIMEOUT`, default 15: number of consecutive not-ready cycles tolerated in a memory state before trapping. Range 1..255.

Ports. Clock is `clk_i`. Reset is `rst_i`: synchronous, active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `instr_op_i` in 6: opcode field. It must be valid during the ID state.
- `mem_ready_i` in 1: memory has completed the current access.
- `pc_write_o` out 1: PC ← PC+4.
- `ir_write_o` out 1: instruction register load.
- `mem_read_o` out 1: memory read request.
- `mem_write_o` out 1: memory write request.
- `reg_write_o` out 1: register file write.
- `reg_dst_o` out 1: 1 selects rd, 0 selects rt.
- `alu_src_o` out 1: 1 selects the sign-extended immediate.
- `mem_to_reg_o` out 1: writeback data comes from memory.
- `alu_op_o` out `ALU_OP_W`: ALU operation class.
- `branch_o` out 1: conditional branch evaluation.
- `branch_ne_o` out 1: branch on not-equal (bne).
- `jump_o` out 1: jump target select.
- `instr_done_o` out 1: 1-cycle pulse on the last state of each instruction.
- `illegal_o` out 1: 1-cycle pulse on an unsupported opcode.
- `err_o` out 1: sticky memory-timeout trap.
- `state_o` out 3: current state, for debug.

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7.
- Reset: the next state is IF and the timeout counter clears. While `rst_i` is high, every output is 0 except `state_o`, which reads 0.
- IF:
  - `mem_read_o`=1.
  - When `mem_ready_i`=1: `pc_write_o`=`ir_write_o`=1 for that cycle only, then go to ID.
  - Otherwise stay in IF.
- ID:
  - `instr_op_i` is latched into an internal opcode register. EX, MEM and WB use only the latched opcode.
  - Illegal opcode: `illegal_o`=1 and `instr_done_o`=1 for this cycle, then go to IF.
- Instruction flows, with `alu_op_o`, `alu_src_o` and `reg_dst_o` held through EX/MEM/WB:
  - R-type 000000: EX → WB. ALU 010, src 0, dst 1.
  - lw 100011: EX → MEM (read) → WB. ALU 000, src 1, dst 0, `mem_to_reg_o`=1 in WB.
  - sw 101011: EX → MEM (`mem_write_o`=1). ALU 000, src 1. The instruction ends in MEM.
  - beq 000100: EX only. ALU 001, `branch_o`=1.
  - bne 000101: EX only. ALU 101, `branch_o`=1, `branch_ne_o`=1.
  - addi 001000 → ALU 000; sltiu 001011 → ALU 010; lui 001111 → ALU 110; ori 001101 → ALU 100. Each runs EX → WB with src 1, dst 0.
- `reg_write_o`=1 only in WB.
- `instr_done_o`=1 in the final state of each flow, and the next state is IF.
- MEM:
  - The request stays asserted while `mem_ready_i`=0.
  - The state advances on the cycle `mem_ready_i`=1.
- Outputs not listed for a state are 0. `alu_op_o` is 0 in IF and ID.

## Timing
- All outputs are Moore outputs: decoded from the state register and latched opcode. The only exceptions are `pc_write_o` and `ir_write_o`, which are gated by `mem_ready_i`.
- Minimum latency with zero-wait memory, IF to done:
  - beq/bne/j: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
- Timeout counter:
  - Increments each cycle spent in IF or MEM with `mem_ready_i`=0.
  - Clears on any state change.
  - When it reaches `MEM_TIMEOUT` while `mem_ready_i` is still 0, the next state is ERR.
  - A ready that arrives on the cycle the count hits the limit wins: no trap.
- ERR: `err_o`=1 and all strobes are 0. Only `rst_i` exits it.
- Reset mid-instruction: abandon the instruction, no writes. IF starts on the first cycle after `rst_i` falls.

## Configuration
- `MULTICYCLE_CTRL_JUMP_EN` defined: opcode 000010 (j) is legal. Flow: ID → EX with `jump_o`=1 and `pc_write_o`=1 in EX, then `instr_done_o`.
- Not defined: 000010 is illegal (`illegal_o` pulse), and `jump_o` is tied to 0.

## Test plan
- Reset, then lw (100011) with `mem_ready_i` held at 1 → states 0,1,2,3,4. `mem_to_reg_o`=`reg_write_o`=1 only in state 4. `instr_done_o` in state 4. 5 cycles total.
- beq, then bne, back-to-back with zero wait → each takes 3 cycles. `branch_o`=1 in EX for both. `branch_ne_o`=1 only for bne. ALU 001 then 101.
- IF with `mem_ready_i` low for 14 cycles, then high, with `MEM_TIMEOUT`=15 → no trap. Low for 15 cycles → state 7, `err_o`=1 until reset.
- Opcode 111111 in ID → `illegal_o`=1 for 1 cycle, no `reg_write_o` or `mem_write_o`, next state IF.
- sw stalled in MEM with `rst_i` asserted → `mem_write_o` drops in the reset cycle, no writes follow, and IF resumes after reset.
- j (000010) → with the macro: 3 cycles, `jump_o`=1 in EX. Without the macro: `illegal_o` pulses.
